// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, controller states and
// the status-register bit layout used by the flag outputs.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_CMP   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SHIFT = 4'd6;
    localparam logic [3:0] OP_MUL   = 4'd7;
    localparam logic [3:0] OP_DIV   = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam int FLAG_CARRY    = 0;
    localparam int FLAG_LOW      = 2;
    localparam int FLAG_FLAG     = 5;
    localparam int FLAG_ZERO     = 6;
    localparam int FLAG_NEGATIVE = 7;

    // Places the individual flags at their status-register bit positions.
    function automatic logic [7:0] pack_status(input logic zero, input logic negative,
                                               input logic low, input logic flag,
                                               input logic carry);
        logic [7:0] s;
        s                = '0;
        s[FLAG_ZERO]     = zero;
        s[FLAG_NEGATIVE] = negative;
        s[FLAG_LOW]      = low;
        s[FLAG_FLAG]     = flag;
        s[FLAG_CARRY]    = carry;
        return s;
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/result bundle between the datapath controller (master) and the ALU (slave).
interface alu_multicycle_if #(parameter int WIDTH = 16);
    logic             start;
    logic             ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             carry;
    logic             low;
    logic             flag;
    logic             zero;
    logic             negative;

    modport master (
        output start, operation, a, b,
        input  ready, result, result_valid, carry, low, flag, zero, negative
    );

    modport slave (
        input  start, operation, a, b,
        output ready, result, result_valid, carry, low, flag, zero, negative
    );
endinterface

// File: rtl/fixed_point_divider.sv
// Iterative signed fixed-point divider: restoring division of magnitudes, one
// quotient bit per cycle, first bit on the start edge; done marks the finishing edge.
module fixed_point_divider #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic             overflow
);
    localparam int N     = WIDTH + FRAC_BITS;
    localparam int CNT_W = $clog2(N + 1);

    logic             busy_reg, neg_reg, zero_div_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] rem_reg, div_reg;
    logic [N-1:0]     dend_reg, quo_reg;

    logic [WIDTH-1:0] a_mag, b_mag, src_rem, src_div, rem_next;
    logic [N-1:0]     src_dend, src_quo, quo_next;
    logic [WIDTH:0]   r_shift;
    logic             ge, q_big, q_is_min, sat;

    always_comb begin
        a_mag    = a[WIDTH-1] ? -a : a;
        b_mag    = b[WIDTH-1] ? -b : b;
        // On the start edge the step works on fresh operands instead of the registers.
        src_rem  = start ? '0 : rem_reg;
        src_div  = start ? b_mag : div_reg;
        src_dend = start ? {a_mag, {FRAC_BITS{1'b0}}} : dend_reg;
        src_quo  = start ? '0 : quo_reg;
        r_shift  = {src_rem, src_dend[N-1]};
        ge       = r_shift >= {1'b0, src_div};
        rem_next = ge ? WIDTH'(r_shift - {1'b0, src_div}) : WIDTH'(r_shift);
        quo_next = (src_quo << 1) | N'(ge);
        q_big    = |quo_next[N-1:WIDTH-1];
        q_is_min = quo_next == (N'(1) << (WIDTH-1));
        sat      = zero_div_reg || (q_big && !(neg_reg && q_is_min));
        if (sat) begin
            quotient = neg_reg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            quotient = neg_reg ? -quo_next[WIDTH-1:0] : quo_next[WIDTH-1:0];
        end
        overflow = sat;
        done     = busy_reg && (cnt_reg == CNT_W'(N-1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_reg     <= 1'b0;
            neg_reg      <= 1'b0;
            zero_div_reg <= 1'b0;
            cnt_reg      <= '0;
            rem_reg      <= '0;
            div_reg      <= '0;
            dend_reg     <= '0;
            quo_reg      <= '0;
        end else if (start || busy_reg) begin
            rem_reg  <= rem_next;
            div_reg  <= src_div;
            dend_reg <= src_dend << 1;
            quo_reg  <= quo_next;
            if (start) begin
                busy_reg     <= 1'b1;
                cnt_reg      <= CNT_W'(1);
                neg_reg      <= a[WIDTH-1] ^ b[WIDTH-1];
                zero_div_reg <= (b == '0);
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
                if (done) busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift, iterative signed Q-format
// multiply, and an iterative divider built only when ALU_DIVIDE_EN is defined.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 8
) (
    input logic             clock,
    input logic             reset,
    alu_multicycle_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + FRAC_BITS + 1);
    localparam int PW    = 2 * WIDTH;

    state_t           state_reg;
    logic [WIDTH-1:0] result_reg;
    logic             result_valid_reg, carry_reg, low_reg, flag_reg, zero_reg, negative_reg;
    logic [PW-1:0]    mul_acc_reg, mul_mcand_reg;
    logic [WIDTH-1:0] mul_mplier_reg;
    logic             mul_neg_reg;
    logic [CNT_W-1:0] mul_cnt_reg;

    logic             a_msb, b_msb;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_sum, sub_diff;
    logic [WIDTH-1:0] sc_result;
    logic             sc_carry, sc_low, sc_flag, sc_zero, sc_negative;

    assign a_msb = bus.a[WIDTH-1];
    assign b_msb = bus.b[WIDTH-1];
    assign a_mag = a_msb ? -bus.a : bus.a;
    assign b_mag = b_msb ? -bus.b : bus.b;

    always_comb begin
        add_sum     = {1'b0, bus.a} + {1'b0, bus.b};
        sub_diff    = {1'b0, bus.a} - {1'b0, bus.b};
        sc_result   = '0;
        sc_carry    = 1'b0;
        sc_low      = 1'b0;
        sc_flag     = 1'b0;
        sc_zero     = 1'b0;
        sc_negative = 1'b0;
        case (bus.operation)
            OP_ADD: begin
                sc_result = add_sum[WIDTH-1:0];
                sc_carry  = add_sum[WIDTH];
                sc_flag   = (a_msb == b_msb) && (add_sum[WIDTH-1] != a_msb);
                sc_zero   = (add_sum[WIDTH-1:0] == '0);
            end
            OP_SUB: begin
                sc_result = sub_diff[WIDTH-1:0];
                sc_carry  = sub_diff[WIDTH];
                sc_flag   = (a_msb != b_msb) && (sub_diff[WIDTH-1] != a_msb);
                sc_zero   = (sub_diff[WIDTH-1:0] == '0);
            end
            OP_CMP: begin
                sc_result   = sub_diff[WIDTH-1:0];
                sc_zero     = (bus.a == bus.b);
                sc_low      = sub_diff[WIDTH];
                sc_negative = $signed(bus.a) < $signed(bus.b);
            end
            OP_AND: sc_result = bus.a & bus.b;
            OP_OR:  sc_result = bus.a | bus.b;
            OP_XOR: sc_result = bus.a ^ bus.b;
            // Signed shift amount: the magnitude of a picks the distance, its sign the direction.
            OP_SHIFT: begin
                if (a_mag >= WIDTH'(WIDTH)) sc_result = '0;
                else sc_result = a_msb ? (bus.b >> a_mag) : (bus.b << a_mag);
            end
            default: ;
        endcase
    end

    logic [PW-1:0]           mul_acc_next, mul_prod;
    logic [PW-FRAC_BITS-1:0] mul_upper;
    logic [WIDTH-1:0]        mul_result;
    logic [WIDTH-FRAC_BITS:0] mul_hi;
    logic                    mul_ovf;

    always_comb begin
        mul_acc_next = mul_acc_reg + (mul_mplier_reg[0] ? mul_mcand_reg : '0);
        mul_prod     = mul_neg_reg ? -mul_acc_next : mul_acc_next;
        mul_upper    = (PW-FRAC_BITS)'(mul_prod >> FRAC_BITS);
        mul_result   = mul_upper[WIDTH-1:0];
        // Discarded high bits plus the result MSB must all agree for an in-range product.
        mul_hi       = mul_upper[PW-FRAC_BITS-1:WIDTH-1];
        mul_ovf      = !((&mul_hi) || !(|mul_hi));
    end

`ifdef ALU_DIVIDE_EN
    logic             div_start, div_done, div_overflow;
    logic [WIDTH-1:0] div_quotient;

    assign div_start = bus.start && (state_reg == IDLE) && (bus.operation == OP_DIV);

    fixed_point_divider #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_divider (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .a        (bus.a),
        .b        (bus.b),
        .done     (div_done),
        .quotient (div_quotient),
        .overflow (div_overflow)
    );
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            carry_reg        <= 1'b0;
            low_reg          <= 1'b0;
            flag_reg         <= 1'b0;
            zero_reg         <= 1'b0;
            negative_reg     <= 1'b0;
            mul_acc_reg      <= '0;
            mul_mcand_reg    <= '0;
            mul_mplier_reg   <= '0;
            mul_neg_reg      <= 1'b0;
            mul_cnt_reg      <= '0;
        end else begin
            result_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: if (bus.start) begin
                    if (bus.operation == OP_MUL) begin
                        // Multiplier bit 0 is folded in on the accepting edge.
                        mul_acc_reg    <= b_mag[0] ? PW'(a_mag) : '0;
                        mul_mcand_reg  <= PW'(a_mag) << 1;
                        mul_mplier_reg <= b_mag >> 1;
                        mul_neg_reg    <= a_msb ^ b_msb;
                        mul_cnt_reg    <= CNT_W'(1);
                        state_reg      <= MUL;
                    end
`ifdef ALU_DIVIDE_EN
                    else if (bus.operation == OP_DIV) begin
                        state_reg <= DIV;
                    end
`endif
                    else begin
                        result_reg       <= sc_result;
                        carry_reg        <= sc_carry;
                        low_reg          <= sc_low;
                        flag_reg         <= sc_flag;
                        zero_reg         <= sc_zero;
                        negative_reg     <= sc_negative;
                        result_valid_reg <= 1'b1;
                    end
                end
                MUL: begin
                    mul_acc_reg    <= mul_acc_next;
                    mul_mcand_reg  <= mul_mcand_reg << 1;
                    mul_mplier_reg <= mul_mplier_reg >> 1;
                    mul_cnt_reg    <= mul_cnt_reg + 1'b1;
                    if (mul_cnt_reg == CNT_W'(WIDTH-1)) begin
                        result_reg       <= mul_result;
                        carry_reg        <= 1'b0;
                        low_reg          <= 1'b0;
                        flag_reg         <= mul_ovf;
                        zero_reg         <= (mul_result == '0);
                        negative_reg     <= mul_result[WIDTH-1];
                        result_valid_reg <= 1'b1;
                        state_reg        <= IDLE;
                    end
                end
`ifdef ALU_DIVIDE_EN
                DIV: if (div_done) begin
                    result_reg       <= div_quotient;
                    carry_reg        <= 1'b0;
                    low_reg          <= 1'b0;
                    flag_reg         <= div_overflow;
                    zero_reg         <= (div_quotient == '0);
                    negative_reg     <= div_quotient[WIDTH-1];
                    result_valid_reg <= 1'b1;
                    state_reg        <= IDLE;
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ready        = (state_reg == IDLE);
    assign bus.result       = result_reg;
    assign bus.result_valid = result_valid_reg;
    assign bus.carry        = carry_reg;
    assign bus.low          = low_reg;
    assign bus.flag         = flag_reg;
    assign bus.zero         = zero_reg;
    assign bus.negative     = negative_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle with a queue scoreboard and an
// independent result monitor that checks data, flags and latency.
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int W = 16;
    localparam int F = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    alu_multicycle_if #(.WIDTH(W)) bus();

    alu_multicycle #(.WIDTH(W), .FRAC_BITS(F)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic [7:0]   st;
        int           due;
    } exp_t;

    exp_t sb_q[$];
    int   tests     = 0;
    int   fails     = 0;
    int   cycle_cnt = 0;

    function automatic logic [7:0] dut_status();
        return pack_status(bus.zero, bus.negative, bus.low, bus.flag, bus.carry);
    endfunction

    // Monitor: pops one expectation per result_valid pulse.
    always @(posedge clock) begin
        exp_t e;
        cycle_cnt++;
        #1;
        if (bus.result_valid) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: result=%h at cycle %0d, required no result_valid",
                         bus.result, cycle_cnt);
            end else begin
                e = sb_q.pop_front();
                tests++;
                if (bus.result !== e.res || dut_status() !== e.st) begin
                    fails++;
                    $display("FAIL %s: result=%h status=%h, required result=%h status=%h",
                             e.name, bus.result, dut_status(), e.res, e.st);
                end else begin
                    $display("[TB] %s: result=%h status=%h cycle=%0d",
                             e.name, bus.result, dut_status(), cycle_cnt);
                end
                tests++;
                if (cycle_cnt != e.due) begin
                    fails++;
                    $display("FAIL %s_latency: valid at cycle %0d, required %0d",
                             e.name, cycle_cnt, e.due);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        @(negedge clock);
        while (!bus.ready && guard < 200) begin
            bus.start = 1'b0;
            guard++;
            @(negedge clock);
        end
        if (!bus.ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: ready=0 after %0d cycles, required 1", guard);
        end
        bus.start     = 1'b1;
        bus.operation = op;
        bus.a         = a;
        bus.b         = b;
    endtask

    task automatic expect_res(input string name, input logic [W-1:0] res,
                              input logic z, input logic n, input logic l,
                              input logic f, input logic c, input int lat);
        exp_t e;
        e.name = name;
        e.res  = res;
        e.st   = pack_status(z, n, l, f, c);
        e.due  = cycle_cnt + lat;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
    endtask

    task automatic drain();
        int g = 0;
        while (sb_q.size() != 0 && g < 300) begin
            @(negedge clock);
            bus.start = 1'b0;
            g++;
        end
    endtask

    task automatic count_busy(input string name, input int want);
        int low_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (bus.ready) break;
            low_cnt++;
        end
        chk(name, low_cnt, want);
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.operation = '0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(negedge clock);
        chk("reset_ready", bus.ready, 1);
        chk("reset_result", bus.result, 0);
        chk("reset_valid", bus.result_valid, 0);
        chk("reset_status", dut_status(), 0);
        reset = 1'b0;

        // Single-cycle ops, back to back: one result per cycle.
        //                                   res       z  n  l  f  c  lat
        issue(OP_ADD, 16'h7FFF, 16'h0001); expect_res("add_ovf",   16'h8000, 0, 0, 0, 1, 0, 1);
        issue(OP_ADD, 16'hFFFF, 16'h0001); expect_res("add_carry", 16'h0000, 1, 0, 0, 0, 1, 1);
        issue(OP_SUB, 16'h8000, 16'h0001); expect_res("sub_ovf",   16'h7FFF, 0, 0, 0, 1, 0, 1);
        issue(OP_CMP, 16'h0001, 16'hFFFF); expect_res("cmp_b2b",   16'h0002, 0, 0, 1, 0, 0, 1);
        issue(OP_SUB, 16'h0000, 16'h0001); expect_res("sub_b2b",   16'hFFFF, 0, 0, 0, 0, 1, 1);
        issue(OP_CMP, 16'h8000, 16'h0001); expect_res("cmp_sneg",  16'h7FFF, 0, 1, 0, 0, 0, 1);
        issue(OP_CMP, 16'h1234, 16'h1234); expect_res("cmp_eq",    16'h0000, 1, 0, 0, 0, 0, 1);
        issue(OP_AND, 16'hF0F0, 16'h3C3C); expect_res("and",       16'h3030, 0, 0, 0, 0, 0, 1);
        issue(OP_OR,  16'hF0F0, 16'h3C3C); expect_res("or",        16'hFCFC, 0, 0, 0, 0, 0, 1);
        issue(OP_XOR, 16'hF0F0, 16'h3C3C); expect_res("xor",       16'hCCCC, 0, 0, 0, 0, 0, 1);
        issue(OP_SHIFT, 16'h0004, 16'h1234); expect_res("shl4",    16'h2340, 0, 0, 0, 0, 0, 1);
        issue(OP_SHIFT, 16'hFFFC, 16'h1234); expect_res("shr4",    16'h0123, 0, 0, 0, 0, 0, 1);
        issue(OP_SHIFT, 16'h000F, 16'h0001); expect_res("shl15",   16'h8000, 0, 0, 0, 0, 0, 1);
        issue(OP_SHIFT, 16'hFFF1, 16'h8000); expect_res("shr15",   16'h0001, 0, 0, 0, 0, 0, 1);
        issue(OP_SHIFT, 16'h0010, 16'hFFFF); expect_res("shl16",   16'h0000, 0, 0, 0, 0, 0, 1);
        issue(OP_SHIFT, 16'hFFF0, 16'hFFFF); expect_res("shr16",   16'h0000, 0, 0, 0, 0, 0, 1);
        issue(4'd15,  16'hFFFF, 16'hFFFF); expect_res("undef15",   16'h0000, 0, 0, 0, 0, 0, 1);
        idle(1);

`ifdef ALU_DIVIDE_EN
        issue(OP_DIV, 16'h0300, 16'h0200); expect_res("div_3_2",   16'h0180, 0, 0, 0, 0, 0, W + F);
        count_busy("div_busy_cycles", W + F - 1);
        issue(OP_DIV, 16'h0100, 16'h0000); expect_res("div_zero",  16'h7FFF, 0, 0, 0, 1, 0, W + F);
        issue(OP_DIV, 16'hFD00, 16'h0200); expect_res("div_neg",   16'hFE80, 0, 1, 0, 0, 0, W + F);
        issue(OP_DIV, 16'h7F00, 16'h0080); expect_res("div_sat",   16'h7FFF, 0, 0, 0, 1, 0, W + F);
`else
        issue(OP_DIV, 16'h0300, 16'h0200); expect_res("op8_undef", 16'h0000, 0, 0, 0, 0, 0, 1);
`endif

        issue(OP_MUL, 16'h0180, 16'hFE00); expect_res("mul_mixed", 16'hFD00, 0, 1, 0, 0, 0, W);
        count_busy("mul_busy_cycles", W - 1);
        issue(OP_MUL, 16'h7F00, 16'h0200); expect_res("mul_ovf",   16'hFE00, 0, 1, 0, 1, 0, W);
        issue(OP_MUL, 16'hFF00, 16'hFF00); expect_res("mul_negneg",16'h0100, 0, 0, 0, 0, 0, W);
        issue(OP_MUL, 16'h0000, 16'h1234); expect_res("mul_zero",  16'h0000, 1, 0, 0, 0, 0, W);

        // Starts and operand changes while busy must be dropped.
        issue(OP_MUL, 16'h0180, 16'hFE00); expect_res("mul_busy_drop", 16'hFD00, 0, 1, 0, 0, 0, W);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            bus.start     = (i % 2 == 0);
            bus.operation = OP_ADD;
            bus.a         = 16'h0001;
            bus.b         = 16'h0001;
        end
        idle(1);
        drain();

        // Reset on the fifth cycle of a multiply aborts it silently.
        issue(OP_MUL, 16'h0180, 16'hFE00);
        idle(4);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_result", bus.result, 0);
        chk("abort_valid", bus.result_valid, 0);
        chk("abort_status", dut_status(), 0);
        @(negedge clock);
        chk("ready_after_reset", bus.ready, 1);
        idle(20);

        drain();
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
